// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: grants, latches operands,
// holds alu_en for SETTLE_CYCLES, then captures the result. Optional macro: ALU_FLAGS_EN (zero_out_o).
module alu_arbiter #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic             op0_i,
  input  logic             op1_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic [1:0]       ack_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] res_out_o,
  output logic             carry_out_o,
`ifdef ALU_FLAGS_EN
  output logic             zero_out_o,
`endif
  output logic             busy_o,
  output logic             alu_en_o,
  output logic             alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_res_i,
  input  logic             alu_carry_i
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             gnt_q;
  logic             last_grant_q;
  logic [1:0]       ack_q;
  logic [1:0]       done_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             busy_q;
  logic             en_q;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
`ifdef ALU_FLAGS_EN
  logic             zero_q;
`endif

  logic             win_d;
  logic             op_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  // On contention the requester that did not win last time is served.
  always_comb begin
    win_d = 1'b0;
    unique case (req_i)
      2'b10:   win_d = 1'b1;
      2'b11:   win_d = ~last_grant_q;
      default: win_d = 1'b0;
    endcase
    op_d = win_d ? op1_i : op0_i;
    a_d  = win_d ? a1_i  : a0_i;
    b_d  = win_d ? b1_i  : b0_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ack_q        <= '0;
      done_q       <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      busy_q       <= 1'b0;
      en_q         <= 1'b0;
      op_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
`ifdef ALU_FLAGS_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q  <= '0;
          done_q <= '0;
          if (|req_i) begin
            gnt_q   <= win_d;
            ack_q   <= win_d ? 2'b10 : 2'b01;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          ack_q <= '0;
          if (cnt_q == CNT_LAST) begin
            res_q        <= alu_res_i;
            carry_q      <= alu_carry_i;
`ifdef ALU_FLAGS_EN
            zero_q       <= (alu_res_i == '0);
`endif
            done_q       <= gnt_q ? 2'b10 : 2'b01;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= gnt_q;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign done_o      = done_q;
  assign res_out_o   = res_q;
  assign carry_out_o = carry_q;
  assign busy_o      = busy_q;
  assign alu_en_o    = en_q;
  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
`ifdef ALU_FLAGS_EN
  assign zero_out_o  = zero_q;
`endif

endmodule
